// File: rtl/match_sequencer.sv
// match_sequencer: T20 match controller counting runs, wickets and legal balls
// and sequencing innings 1, break, innings 2 chase and the result.
module match_sequencer #(
    parameter int MAX_BALLS = 120,
    parameter int MAX_WKTS  = 10,
    parameter int RUN_W     = 8
) (
    input  logic             clk_fpga,
    input  logic             reset,
    input  logic             start,
    input  logic             ball_valid,
    output logic             ball_ready,
    input  logic [2:0]       ball_runs,
    input  logic             ball_wicket,
    input  logic             ball_extra,
    output logic [2:0]       state,
    output logic             batting_team,
    output logic [RUN_W-1:0] cur_runs,
    output logic [3:0]       cur_wkts,
    output logic [6:0]       cur_balls,
    output logic [RUN_W+3:0] team1Data,
    output logic [RUN_W+3:0] team2Data,
    output logic [RUN_W:0]   target,
    output logic             inningOver,
    output logic             gameOver,
    output logic [1:0]       winner
);
    typedef enum logic [2:0] {IDLE, INN1, BREAK, INN2, RESULT, DONE} state_t;
    state_t st;
    logic [2:0] run_eff;
    logic [RUN_W:0] run_sum;
    logic [RUN_W-1:0] run_next;
    logic chased, ended, accept;
    assign state = st;
    assign run_eff = (ball_runs == 3'd7) ? 3'd6 : ball_runs;
    assign run_sum = {1'b0, cur_runs} + (RUN_W+1)'(run_eff) + (RUN_W+1)'(ball_extra);
    assign run_next = run_sum[RUN_W] ? '1 : run_sum[RUN_W-1:0];
    // target is one bit wider than runs, so a saturated first innings yields an unreachable chase
    assign chased = {1'b0, cur_runs} >= target;
    assign ended = cur_wkts == 4'(MAX_WKTS) || cur_balls == 7'(MAX_BALLS) || (st == INN2 && chased);
    assign ball_ready = (st == INN1 || st == INN2) && !ended;
    assign accept = ball_valid && ball_ready;
    assign inningOver = st == BREAK || st == RESULT || st == DONE;
    assign gameOver = st == DONE;
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            st <= IDLE;
            batting_team <= 1'b0;
            cur_runs <= '0;
            cur_wkts <= '0;
            cur_balls <= '0;
            team1Data <= '0;
            team2Data <= '0;
            target <= '0;
            winner <= '0;
        end else begin
            if (accept) begin
                cur_runs <= run_next;
                if (!ball_extra) begin
                    cur_balls <= cur_balls + 7'd1;
                    cur_wkts <= cur_wkts + {3'b0, ball_wicket};
                end
            end
            case (st)
                IDLE, DONE: if (start) begin
                    st <= INN1;
                    batting_team <= 1'b0;
                    cur_runs <= '0;
                    cur_wkts <= '0;
                    cur_balls <= '0;
                    team1Data <= '0;
                    team2Data <= '0;
                    target <= '0;
                    winner <= '0;
                end
                INN1: if (ended) begin
                    st <= BREAK;
                    team1Data <= {cur_runs, cur_wkts};
                    target <= {1'b0, cur_runs} + (RUN_W+1)'(1);
                    cur_runs <= '0;
                    cur_wkts <= '0;
                    cur_balls <= '0;
                end
                BREAK: if (start) begin
                    st <= INN2;
                    batting_team <= 1'b1;
                end
                INN2: begin
                    team2Data <= {cur_runs, cur_wkts};
                    if (ended) st <= RESULT;
                end
                RESULT: begin
                    winner <= chased ? 2'd2 : (team1Data[RUN_W+3:4] > cur_runs ? 2'd1 : 2'd3);
                    st <= DONE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: scoreboard bench driving whole matches through match_sequencer
// against an independent behavioural model of the scoring rules.
module tb_match_sequencer;
    logic clk_fpga = 0, reset = 1, start = 0, ball_valid = 0, ball_wicket = 0, ball_extra = 0;
    logic [2:0] ball_runs = 0;
    logic ball_ready, batting_team, inningOver, gameOver;
    logic [2:0] state;
    logic [7:0] cur_runs;
    logic [3:0] cur_wkts;
    logic [6:0] cur_balls;
    logic [11:0] team1Data, team2Data;
    logic [8:0] target;
    logic [1:0] winner;

    match_sequencer dut (
        .clk_fpga(clk_fpga), .reset(reset), .start(start), .ball_valid(ball_valid),
        .ball_ready(ball_ready), .ball_runs(ball_runs), .ball_wicket(ball_wicket),
        .ball_extra(ball_extra), .state(state), .batting_team(batting_team),
        .cur_runs(cur_runs), .cur_wkts(cur_wkts), .cur_balls(cur_balls),
        .team1Data(team1Data), .team2Data(team2Data), .target(target),
        .inningOver(inningOver), .gameOver(gameOver), .winner(winner)
    );

    always #5 clk_fpga = ~clk_fpga;

    int n_cmp = 0, n_bad = 0;
    int m_state, m_runs, m_wkts, m_balls, m_t1r, m_t1w, m_target, m_win, m_bat;
    typedef struct {int r; int w; int b;} exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_end();
        return m_wkts == 10 || m_balls == 120 || (m_state == 3 && m_runs >= m_target);
    endfunction

    function automatic bit m_ready();
        return (m_state == 1 || m_state == 3) && !m_end();
    endfunction

    task automatic settle();
        @(negedge clk_fpga);
        if (m_state == 1) begin
            m_state = 2;
            m_t1r = m_runs; m_t1w = m_wkts; m_target = m_runs + 1;
            m_runs = 0; m_wkts = 0; m_balls = 0;
            chk("brk_state", state, 2);
            chk("brk_team1", team1Data, m_t1r * 16 + m_t1w);
            chk("brk_target", target, m_target);
            chk("brk_runs", cur_runs, 0);
            chk("brk_balls", cur_balls, 0);
            chk("brk_over", inningOver, 1);
            chk("brk_ready", ball_ready, 0);
        end else begin
            chk("res_state", state, 4);
            chk("res_team2", team2Data, m_runs * 16 + m_wkts);
            m_win = m_runs >= m_target ? 2 : (m_t1r > m_runs ? 1 : 3);
            @(negedge clk_fpga);
            m_state = 5;
            chk("done_state", state, 5);
            chk("done_winner", winner, m_win);
            chk("done_game", gameOver, 1);
            chk("done_over", inningOver, 1);
            chk("done_balls", cur_balls, m_balls);
            chk("done_team1", team1Data, m_t1r * 16 + m_t1w);
        end
    endtask

    task automatic ball(input int r, input bit w, input bit e);
        bit acc;
        exp_t x;
        acc = m_ready();
        chk("ready", ball_ready, 32'(acc));
        ball_runs = 3'(r); ball_wicket = w; ball_extra = e; ball_valid = 1;
        if (acc) begin
            m_runs += (e ? 1 : 0) + (r > 6 ? 6 : r);
            if (m_runs > 255) m_runs = 255;
            if (!e) begin
                m_balls++;
                m_wkts += int'(w);
            end
            sb.push_back('{m_runs, m_wkts, m_balls});
        end
        @(negedge clk_fpga);
        ball_valid = 0;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("runs", cur_runs, x.r);
            chk("wkts", cur_wkts, x.w);
            chk("balls", cur_balls, x.b);
        end
        if (acc && m_end()) settle();
    endtask

    task automatic start_pulse();
        start = 1;
        @(negedge clk_fpga);
        start = 0;
        if (m_state == 0 || m_state == 5) begin
            m_state = 1; m_bat = 0; m_runs = 0; m_wkts = 0; m_balls = 0;
            m_t1r = 0; m_t1w = 0; m_target = 0; m_win = 0;
            chk("new_team2", team2Data, 0);
            chk("new_runs", cur_runs, 0);
        end else if (m_state == 2) begin
            m_state = 3; m_bat = 1;
        end
        chk("st_state", state, m_state);
        chk("st_bat", batting_team, m_bat);
        chk("st_winner", winner, m_win);
        chk("st_team1", team1Data, m_t1r * 16 + m_t1w);
        chk("st_target", target, m_target);
    endtask

    task automatic do_reset();
        @(negedge clk_fpga);
        reset = 1;
        #1;
        m_state = 0; m_bat = 0; m_runs = 0; m_wkts = 0; m_balls = 0;
        m_t1r = 0; m_t1w = 0; m_target = 0; m_win = 0;
        sb.delete();
        chk("rst_state", state, 0);
        chk("rst_ready", ball_ready, 0);
        chk("rst_runs", cur_runs, 0);
        chk("rst_balls", cur_balls, 0);
        chk("rst_team1", team1Data, 0);
        chk("rst_team2", team2Data, 0);
        chk("rst_target", target, 0);
        chk("rst_winner", winner, 0);
        chk("rst_flags", {batting_team, inningOver, gameOver}, 0);
        @(negedge clk_fpga);
        reset = 0;
    endtask

    task automatic team1_hundred();
        start_pulse();
        repeat (16) ball(6, 0, 0);
        ball(4, 0, 0);
        repeat (103) ball(0, 0, 0);
        start_pulse();
    endtask

    initial begin
        do_reset();
        // dot-ball innings, then a dropped event in BREAK, then a one-run chase
        start_pulse();
        repeat (120) ball(0, 0, 0);
        ball(0, 0, 0);
        chk("drop_balls", cur_balls, 0);
        start_pulse();
        ball(1, 0, 0);
        // all out for 10, then team2 all out for 0
        start_pulse();
        repeat (10) ball(1, 1, 0);
        start_pulse();
        repeat (10) ball(0, 1, 0);
        // 150 then a chase finished by a wide
        start_pulse();
        repeat (25) ball(6, 0, 0);
        repeat (95) ball(0, 0, 0);
        start_pulse();
        repeat (25) ball(6, 0, 0);
        ball(0, 0, 1);
        // 100 vs 99, then 100 vs 100
        team1_hundred();
        repeat (16) ball(6, 0, 0);
        repeat (3) ball(1, 0, 0);
        repeat (101) ball(0, 0, 0);
        team1_hundred();
        repeat (16) ball(6, 0, 0);
        ball(4, 0, 0);
        repeat (103) ball(0, 0, 0);
        // reset in the middle of innings 2
        start_pulse();
        repeat (10) ball(6, 1, 0);
        start_pulse();
        repeat (8) ball(6, 0, 0);
        ball(2, 0, 0);
        chk("mid_runs", cur_runs, 50);
        do_reset();
        // saturation: unreachable target of 256
        start_pulse();
        repeat (20) ball(7, 0, 1);
        repeat (30) ball(6, 0, 0);
        repeat (90) ball(0, 0, 0);
        start_pulse();
        repeat (40) ball(6, 0, 1);
        repeat (120) ball(6, 0, 0);
        start_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
Top-level match controller for the T20 scoreboard. It accepts per-delivery ball events and keeps the live runs, wickets and legal-ball counts. It sequences the match through innings 1, the innings break, innings 2 (a chase against a target) and the result. It publishes packed team totals in the scoreboard's {runs, wickets} format for the display and comparison logic downstream.

Parameters:
MAX_BALLS, 120, legal deliveries per innings
MAX_WKTS, 10, wickets that end an innings (all out)
RUN_W, 8, run counter width; runs saturate at 2^RUN_W-1

Ports:
clk_fpga  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clock clk_fpga
start  in  1  one-cycle pulse: begin match (IDLE/DONE) or begin innings 2 (BREAK)
ball_valid  in  1  delivery event present
ball_ready  out  1  controller can accept a delivery this cycle
ball_runs  in  3  runs off the delivery, 0..6; values 7 are treated as 6
ball_wicket  in  1  wicket fell on this delivery
ball_extra  in  1  wide/no-ball: not a legal ball
state  out  3  0 IDLE, 1 INN1, 2 BREAK, 3 INN2, 4 RESULT, 5 DONE
batting_team  out  1  0 team1, 1 team2
cur_runs  out  RUN_W  live runs of the batting side
cur_wkts  out  4  live wickets
cur_balls  out  7  live legal balls
team1Data  out  RUN_W+4  {runs, wickets} of team1, frozen after innings 1
team2Data  out  RUN_W+4  {runs, wickets} of team2, live during INN2
target  out  RUN_W+1  team1 runs + 1, valid from BREAK onward
inningOver  out  1  high while in BREAK, RESULT or DONE
gameOver  out  1  high in DONE
winner  out  2  0 none, 1 team1, 2 team2, 3 tie

Behaviour:
- Reset (async) values: state=IDLE, all counters 0, team1Data/team2Data/target 0, ball_ready/inningOver/gameOver 0, winner 0, batting_team 0.
- ball_ready=1 only in INN1/INN2 when no end condition holds on the registered counters. An event is accepted on ball_valid && ball_ready. Events at any other time are dropped and change nothing.
- Accepted event, legal (ball_extra=0): runs += ball_runs; balls += 1; wkts += ball_wicket.
- Accepted event, extra (ball_extra=1): runs += 1 + ball_runs; balls and wkts unchanged; ball_wicket ignored.
- Run addition saturates at 2^RUN_W-1. Wicket count never exceeds MAX_WKTS; balls never exceed MAX_BALLS.
- All counter updates are registered; the new values are visible the cycle after acceptance.
- End conditions, evaluated on registered counters:
  - INN1: wkts==MAX_WKTS or balls==MAX_BALLS.
  - INN2: the INN1 conditions, or runs >= target.
- IDLE: start -> INN1, counters cleared, batting_team=0.
- INN1: end condition -> BREAK on the next edge. On that edge: team1Data <= {runs, wkts}; target <= runs+1; live counters cleared.
- BREAK: start -> INN2 with batting_team=1. start pulses in INN1/INN2/RESULT are ignored.
- INN2: team2Data tracks live counters every cycle. End condition -> RESULT.
- RESULT: exactly one cycle. winner <= 2 if team2 runs >= target; else 1 if team1 runs > team2 runs; else 3 (tie). Then -> DONE.
- DONE: gameOver=1; winner and totals held. start -> INN1 with all counters, totals, target and winner cleared (new match).
- Latency: accepted ball to counter update = 1 cycle. Final ball to state change = 2 cycles (counter update, then transition).
- A chase completed on an extra ends innings 2 with balls < MAX_BALLS.
- Saturated team1 runs: target = 2^RUN_W, which cannot be reached, so innings 2 ends only by balls or wickets.

Test Plan:
- Reset mid-INN2 (cur_runs=50) -> state=IDLE, all outputs 0, ball_ready=0 immediately without a clock edge.
- INN1: 120 legal dot balls with ball_valid held high -> ball_ready drops after the 120th acceptance; team1Data={0,0}; target=1; state=BREAK. A 121st event is not counted.
- INN1: 10 wicket balls with ball_runs=1 -> team1Data={10,10}, target=11, cur_balls=0 in BREAK.
- INN2 after team1=150: events summing to 151, the last being a wide with ball_runs=0 -> RESULT then DONE; winner=2, gameOver=1, cur_balls<120.
- Team1=100; team2 reaches 99 at 120 balls -> winner=1. Repeat with team2=100 -> winner=3 (tie).
- Saturation (RUN_W=8): 255 runs off 6s and extras -> cur_runs holds 255; target=256; innings 2 ends only on balls or wickets. start in DONE -> INN1 with all totals cleared.
